// File: rtl/axi_lite_arb_pkg.sv
// axi_lite_arb_pkg: shared FSM state type, AXI RESP codes and round-robin grant helper
package axi_lite_arb_pkg;

    localparam int MAX_REQ = 8;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        DONE
    } arb_state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    // One-hot grant: the first set request found at ptr+1, ptr+2, ... modulo n.
    // Walking from the lowest priority upward lets the last hit win.
    function automatic logic [MAX_REQ-1:0] next_rr(
        input logic [MAX_REQ-1:0] req,
        input logic [2:0]         ptr,
        input int                 n = MAX_REQ
    );
        logic [MAX_REQ-1:0] gnt;
        int idx;
        gnt = '0;
        for (int k = MAX_REQ; k >= 1; k--) begin
            idx = (int'(ptr) + k) % n;
            if (k <= n && req[idx[2:0]]) gnt = MAX_REQ'(1) << idx[2:0];
        end
        return gnt;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational one-hot round-robin grant plus the registered last-grant pointer
// Ports: clk_i/rst_i clock and sync active-high reset; req_i request vector; gnt_o one-hot grant;
//        upd_i/upd_idx_i load the pointer with the index of the completed grant.
module rr_arbiter
    import axi_lite_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [N-1:0]  req_i,
    input  logic          upd_i,
    input  logic [IW-1:0] upd_idx_i,
    output logic [N-1:0]  gnt_o
);

    logic [IW-1:0]      ptr_q, ptr_d;
    logic [MAX_REQ-1:0] req_ext, gnt_ext;

    always_comb begin
        req_ext = '0;
        req_ext[N-1:0] = req_i;
        gnt_ext = next_rr(req_ext, 3'(ptr_q), N);
        gnt_o = gnt_ext[N-1:0];
        ptr_d = upd_i ? upd_idx_i : ptr_q;
    end

    // Pointer starts at the last requester so requester 0 has top priority first.
    always_ff @(posedge clk_i) begin
        if (rst_i) ptr_q <= IW'(N - 1);
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/axi_lite_reg_arbiter.sv
// axi_lite_reg_arbiter: round-robin share of one AXI4-Lite master port among NUM_REQ command sources
// Ports: ACLK/ARESET clock and sync active-high reset; req_* command inputs with one-hot req_ready
//        accept pulse; rsp_* one-hot completion pulse with read data and RESP; M_AXI_* master port.
module axi_lite_reg_arbiter
    import axi_lite_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic [1:0]                    rsp_resp,
    output logic [ADDR_WIDTH-1:0]         M_AXI_AWADDR,
    output logic [2:0]                    M_AXI_AWPROT,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]         M_AXI_WDATA,
    output logic [3:0]                    M_AXI_WSTRB,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]         M_AXI_ARADDR,
    output logic [2:0]                    M_AXI_ARPROT,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]         M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
);

    localparam int IW = $clog2(NUM_REQ);

    arb_state_t              state_q, state_d;
    logic [IW-1:0]           gidx_q, gidx_d, sel_idx;
    logic                    wr_q, wr_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d, cmd_addr;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              resp_q, resp_d;
    logic [NUM_REQ-1:0]      gnt;
    logic                    aw_hs, w_hs;

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
        .clk_i     (ACLK),
        .rst_i     (ARESET),
        .req_i     (req_valid),
        .upd_i     (state_q == DONE),
        .upd_idx_i (gidx_q),
        .gnt_o     (gnt)
    );

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) sel_idx = IW'(i);
        cmd_addr = req_addr[int'(sel_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    end

    // VALIDs come only from state and the done flags, never from READY.
    assign aw_hs         = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs          = M_AXI_WVALID && M_AXI_WREADY;
    assign req_ready     = (state_q == IDLE) ? gnt : '0;
    assign rsp_valid     = (state_q == DONE) ? NUM_REQ'(1) << gidx_q : '0;
    assign rsp_rdata     = rdata_q;
    assign rsp_resp      = resp_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_AWVALID = (state_q == WR) && !aw_done_q;
    assign M_AXI_WVALID  = (state_q == WR) && !w_done_q;
    assign M_AXI_BREADY  = state_q == WR_RESP;
    assign M_AXI_ARVALID = state_q == RD_ADDR;
    assign M_AXI_RREADY  = state_q == RD_DATA;

    always_comb begin
        state_d   = state_q;
        gidx_d    = gidx_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        case (state_q)
            IDLE: if (|req_valid) begin
                gidx_d    = sel_idx;
                wr_d      = req_write[sel_idx];
                addr_d    = cmd_addr & ~ADDR_WIDTH'(3);
                wdata_d   = req_wdata[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                state_d   = req_write[sel_idx] ? WR : RD_ADDR;
            end
            WR: begin
                aw_done_d = aw_done_q || aw_hs;
                w_done_d  = w_done_q || w_hs;
                state_d   = (aw_done_d && w_done_d) ? WR_RESP : WR;
            end
            WR_RESP: if (M_AXI_BVALID) begin
                resp_d  = M_AXI_BRESP;
                rdata_d = '0;
                state_d = DONE;
            end
            RD_ADDR: state_d = M_AXI_ARREADY ? RD_DATA : RD_ADDR;
            RD_DATA: if (M_AXI_RVALID) begin
                resp_d  = M_AXI_RRESP;
                rdata_d = M_AXI_RDATA;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= IDLE;
            gidx_q    <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= OKAY;
        end else begin
            state_q   <= state_d;
            gidx_q    <= gidx_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_reg_arbiter.sv
// tb_axi_lite_reg_arbiter: scoreboard bench with a reference register bank and round-robin model
module tb_axi_lite_reg_arbiter;
    import axi_lite_arb_pkg::*;

    localparam int N  = 2;
    localparam int AW = 4;
    localparam int DW = 32;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } cmd_t;

    typedef struct {
        int          g;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          rdy_cyc;
        bit          lat_chk;
    } exp_t;

    logic ACLK = 1'b0;
    logic ARESET = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_write = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic [1:0]      rsp_resp;
    logic [AW-1:0]   awaddr, araddr;
    logic [2:0]      awprot, arprot;
    logic            awvalid, wvalid, bready, arvalid, rready;
    logic [DW-1:0]   wdata;
    logic [3:0]      wstrb;
    logic            awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0;
    logic [1:0]      bresp = 0, rresp = 0;
    logic [DW-1:0]   rdata = 0;

    always #5 ACLK = ~ACLK;

    axi_lite_reg_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    int checks = 0, passed = 0;
    int cyc = 0, done_cyc = -1;
    cmd_t cmdq[N][$];
    exp_t sb[$];
    int grants[$], gcyc[$];
    logic [31:0] ref_mem[4], slv_mem[4], saved[4];
    logic [1:0]  resp_map[4];
    int rr_ptr = N - 1;
    bit lat_mode = 0, rnd_dly = 0;
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    int aw_cyc = 0, w_cyc = 0, b_hs = 0;
    logic [AW-1:0] exp_addr;
    logic [31:0]   exp_wdata;

    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [N-1:0] model_gnt(input logic [N-1:0] v, input int p);
        for (int k = 1; k <= N; k++) if (v[(p + k) % N]) return N'(1) << ((p + k) % N);
        return '0;
    endfunction

    // Stimulus engine: presents queue heads, predicts the grant, pushes expectations on accept.
    initial begin
        bit acc[N];
        logic [N-1:0] exp_rdy;
        int g, idx;
        cmd_t c;
        for (int i = 0; i < N; i++) acc[i] = 0;
        forever begin
            @(negedge ACLK);
            if (ARESET) begin
                for (int i = 0; i < N; i++) acc[i] = 0;
                req_valid = '0;
                continue;
            end
            for (int i = 0; i < N; i++) begin
                if (acc[i]) void'(cmdq[i].pop_front());
                acc[i] = 0;
                req_valid[i] = cmdq[i].size() > 0;
                if (req_valid[i]) begin
                    req_write[i] = cmdq[i][0].wr;
                    req_addr[i*AW +: AW] = cmdq[i][0].addr;
                    req_wdata[i*DW +: DW] = cmdq[i][0].data;
                end
            end
            #1;
            exp_rdy = (sb.size() == 0 && done_cyc != cyc) ? model_gnt(req_valid, rr_ptr) : '0;
            if (req_valid != 0 || req_ready != 0) chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            if (req_ready != 0) begin
                g = 0;
                for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
                acc[g] = 1;
                rr_ptr = g;
                grants.push_back(g);
                gcyc.push_back(cyc);
                c = cmdq[g][0];
                idx = int'(c.addr) / 4;
                exp_addr = AW'(idx * 4);
                exp_wdata = c.data;
                if (c.wr) begin
                    ref_mem[idx] = c.data;
                    sb.push_back('{g, 32'h0, resp_map[idx], cyc, lat_mode});
                end else begin
                    sb.push_back('{g, ref_mem[idx], resp_map[idx], cyc, lat_mode});
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every completion pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge ACLK);
            if (rsp_valid != 0) begin
                if (sb.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 0);
                else begin
                    e = sb.pop_front();
                    chk("rsp_valid", 32'(rsp_valid), 32'(N'(1) << e.g));
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_resp", 32'(rsp_resp), 32'(e.resp));
                    if (e.lat_chk) chk("rsp_latency", 32'(cyc - e.rdy_cyc), 3);
                end
                done_cyc = cyc;
            end
        end
    end

    // Slave: register bank with programmable per-channel READY/VALID delays.
    initial begin
        bit aw_got = 0, w_got = 0, ar_got = 0, b_fire = 0, r_fire = 0;
        int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
        logic [AW-1:0] aw_a = 0, ar_a = 0;
        logic [31:0] w_d = 0;
        forever begin
            @(negedge ACLK);
            if (ARESET) begin
                {aw_got, w_got, ar_got, b_fire, r_fire} = '0;
                {aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt} = '0;
                {awready, wready, bvalid, arready, rvalid} = '0;
                continue;
            end
            if (b_fire) begin
                bvalid = 0;
                b_fire = 0;
            end else begin
                if (!bvalid && aw_got && w_got) begin
                    if (b_cnt >= b_dly) begin
                        slv_mem[aw_a[3:2]] = w_d;
                        bresp = resp_map[aw_a[3:2]];
                        bvalid = 1;
                        {b_cnt, aw_got, w_got} = '0;
                        if (rnd_dly) b_dly = $urandom_range(0, 3);
                    end else b_cnt++;
                end
                if (bvalid) begin
                    b_fire = bready;
                    if (bready) b_hs++;
                end
            end
            if (r_fire) begin
                rvalid = 0;
                r_fire = 0;
            end else begin
                if (!rvalid && ar_got) begin
                    if (r_cnt >= r_dly) begin
                        rdata = slv_mem[ar_a[3:2]];
                        rresp = resp_map[ar_a[3:2]];
                        rvalid = 1;
                        {r_cnt, ar_got} = '0;
                        if (rnd_dly) r_dly = $urandom_range(0, 6);
                    end else r_cnt++;
                end
                if (rvalid) r_fire = rready;
            end
            if (awvalid) aw_cyc++;
            if (awready) awready = 0;
            else if (awvalid) begin
                if (aw_cnt >= aw_dly) begin
                    awready = 1;
                    aw_a = awaddr;
                    aw_got = 1;
                    aw_cnt = 0;
                    chk("awaddr", 32'(awaddr), 32'(exp_addr));
                    chk("awprot", 32'(awprot), 0);
                    if (rnd_dly) aw_dly = $urandom_range(0, 3);
                end else aw_cnt++;
            end
            if (wvalid) w_cyc++;
            if (wready) wready = 0;
            else if (wvalid) begin
                if (w_cnt >= w_dly) begin
                    wready = 1;
                    w_d = wdata;
                    w_got = 1;
                    w_cnt = 0;
                    chk("wdata", wdata, exp_wdata);
                    chk("wstrb", 32'(wstrb), 32'hF);
                    if (rnd_dly) w_dly = $urandom_range(0, 3);
                end else w_cnt++;
            end
            if (arready) arready = 0;
            else if (arvalid) begin
                if (ar_cnt >= ar_dly) begin
                    arready = 1;
                    ar_a = araddr;
                    ar_got = 1;
                    ar_cnt = 0;
                    chk("araddr", 32'(araddr), 32'(exp_addr));
                    chk("arprot", 32'(arprot), 0);
                    if (rnd_dly) ar_dly = $urandom_range(0, 3);
                end else ar_cnt++;
            end
        end
    end

    task automatic push(input int r, input logic wr, input logic [AW-1:0] a, input logic [31:0] d);
        cmdq[r].push_back('{wr, a, d});
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 3000; k++) begin
            @(negedge ACLK);
            if (cmdq[0].size() == 0 && cmdq[1].size() == 0 && sb.size() == 0) break;
        end
        chk("drain_timeout", 32'(k >= 3000), 0);
        repeat (2) @(negedge ACLK);
    endtask

    initial begin
        int k;
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        for (int i = 0; i < 4; i++) begin
            ref_mem[i] = 0;
            slv_mem[i] = 0;
            resp_map[i] = OKAY;
        end
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_resp", 32'(rsp_resp), 0);
        chk("rst_valids", 32'({awvalid, wvalid, arvalid}), 0);
        chk("rst_readies", 32'({bready, rready}), 0);
        ARESET = 0;

        // Write then read back with a zero-wait slave
        lat_mode = 1;
        grants.delete();
        gcyc.delete();
        for (int i = 0; i < 4; i++) push(0, 1, AW'(4 * i), 32'(i + 1));
        for (int i = 0; i < 4; i++) push(0, 0, AW'(4 * i), 0);
        wait_idle();
        chk("t1_grants", 32'(grants.size()), 8);
        for (int i = 1; i < gcyc.size(); i++) chk("t1_regrant_gap", 32'(gcyc[i] - gcyc[i-1]), 4);
        lat_mode = 0;

        // Fairness: both requesters always pending
        grants.delete();
        for (int i = 0; i < 4; i++) begin
            push(0, 0, AW'(4 * i), 0);
            push(1, 0, AW'(4 * (3 - i)), 0);
        end
        wait_idle();
        for (int i = 1; i < grants.size(); i++) chk("t2_alternate", 32'(grants[i]), 32'(1 - grants[i-1]));

        // Independent AW/W handshakes
        aw_dly = 3;
        w_dly = 0;
        @(negedge ACLK);
        {aw_cyc, w_cyc, b_hs} = '0;
        push(1, 1, 4'h8, 32'hA5A5_0001);
        wait_idle();
        chk("t3_awvalid_cycles", 32'(aw_cyc), 4);
        chk("t3_wvalid_cycles", 32'(w_cyc), 1);
        chk("t3_b_handshakes", 32'(b_hs), 1);
        aw_dly = 0;

        // Backpressure and SLVERR pass-through
        ar_dly = 2;
        r_dly = 5;
        resp_map[2] = SLVERR;
        push(0, 1, 4'h8, 32'hDEAD_BEEF);
        push(0, 0, 4'h8, 0);
        wait_idle();
        {ar_dly, r_dly} = '0;
        resp_map[2] = OKAY;

        // Unaligned address
        push(1, 1, 4'h6, 32'h1234_5678);
        push(1, 0, 4'h4, 0);
        wait_idle();

        // Reset while waiting for the write response
        saved = ref_mem;
        b_dly = 20;
        push(0, 1, 4'hC, 32'h0BAD_0BAD);
        for (k = 0; k < 50; k++) begin
            @(negedge ACLK);
            if (bready) break;
        end
        chk("t6_reached_wr_resp", 32'(k < 50), 1);
        ARESET = 1;
        @(posedge ACLK);
        #1;
        chk("t6_valids_after_rst", 32'({awvalid, wvalid, arvalid}), 0);
        chk("t6_rsp_after_rst", 32'(rsp_valid), 0);
        chk("t6_bready_after_rst", 32'(bready), 0);
        @(negedge ACLK);
        sb.delete();
        for (int i = 0; i < N; i++) cmdq[i].delete();
        rr_ptr = N - 1;
        ref_mem = saved;
        b_dly = 0;
        @(negedge ACLK);
        ARESET = 0;
        grants.delete();
        push(1, 0, 4'h0, 0);
        push(0, 0, 4'h4, 0);
        wait_idle();
        chk("t6_first_grant", 32'(grants.size() > 0 ? grants[0] : -1), 0);

        // Randomized traffic
        rnd_dly = 1;
        for (int i = 0; i < 4; i++) resp_map[i] = 2'($urandom_range(0, 3));
        for (int i = 0; i < 80; i++) begin
            push($urandom_range(0, 1), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 6)) @(negedge ACLK);
        end
        wait_idle();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
